// File: rtl/sprite_line_scheduler.sv
// Shares one sprite bitmap ROM among NUM_SPRITES sprites: fetches next-line rows during hblank, picks pixels in active video.
// Optional build macro SPRITE_MIRROR_EN adds per-sprite horizontal mirroring (port sprite_flip).
module sprite_line_scheduler #(
    parameter int NUM_SPRITES = 4,
    parameter int V_TOTAL     = 525
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [9:0]                hpos,
    input  logic [9:0]                vpos,
    input  logic                      hblank_start,
    input  logic                      active,
    input  logic [NUM_SPRITES-1:0]    sprite_en,
    input  logic [10*NUM_SPRITES-1:0] sprite_x,
    input  logic [10*NUM_SPRITES-1:0] sprite_y,
`ifdef SPRITE_MIRROR_EN
    input  logic [NUM_SPRITES-1:0]    sprite_flip,
`endif
    output logic [3:0]                rom_line,
    input  logic [63:0]               rom_bits,
    output logic [2:0]                pixel_rgb,
    output logic                      pixel_hit,
    output logic                      busy
);
    localparam int KW = $clog2(NUM_SPRITES + 1);
    localparam logic [KW-1:0] K_LAST = KW'(NUM_SPRITES);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [9:0]    target_q, target_d;
    logic [3:0]    rom_line_q, rom_line_d;
    logic          busy_q, busy_d;
    logic          fetch_vld_q, fetch_vld_d;
    logic [KW-1:0] fetch_idx_q, fetch_idx_d;
    logic          fetch_hit_q, fetch_hit_d;
    logic [63:0]   line_buf_q [NUM_SPRITES];
    logic [63:0]   line_buf_d [NUM_SPRITES];
    logic [9:0]    xl_q [NUM_SPRITES];
    logic [9:0]    xl_d [NUM_SPRITES];
    logic [2:0]    pixel_rgb_q, pixel_rgb_d;
    logic          pixel_hit_q, pixel_hit_d;

    logic [9:0]    target_next;
    logic [9:0]    sel_y;
    logic          sel_en;
    logic [9:0]    dy;

    assign target_next = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;

    // Row select for the sprite being fetched this cycle; mod-1024 subtraction gives the vertical wrap.
    always_comb begin
        sel_y  = '0;
        sel_en = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (k_q == KW'(i)) begin
                sel_y  = sprite_y[10*i +: 10];
                sel_en = sprite_en[i];
            end
        end
        dy = target_q - sel_y;
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        target_d    = target_q;
        rom_line_d  = rom_line_q;
        fetch_vld_d = 1'b0;
        fetch_idx_d = fetch_idx_q;
        fetch_hit_d = fetch_hit_q;
        if (hblank_start) begin
            state_d  = SCAN;
            k_d      = '0;
            target_d = target_next;
        end else if (state_q == SCAN) begin
            if (k_q == K_LAST) begin
                state_d = IDLE;
            end else begin
                rom_line_d  = dy[3:0];
                fetch_vld_d = 1'b1;
                fetch_idx_d = k_q;
                fetch_hit_d = sel_en && (dy < 10'd16);
                k_d         = k_q + 1'b1;
            end
        end
        busy_d = (state_d == SCAN);
    end

    // ROM data for the address issued last cycle lands here.
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            line_buf_d[i] = line_buf_q[i];
            xl_d[i]       = xl_q[i];
            if (fetch_vld_q && fetch_idx_q == KW'(i)) begin
                line_buf_d[i] = fetch_hit_q ? rom_bits : 64'h0;
                xl_d[i]       = sprite_x[10*i +: 10];
            end
        end
    end

    always_comb begin
        logic [9:0] px;
        logic [3:0] idx;
        logic [3:0] nib;
        logic       hit_c;
        logic [2:0] rgb_c;
        px    = '0;
        idx   = '0;
        nib   = '0;
        hit_c = 1'b0;
        rgb_c = '0;
        // Walk from lowest priority up so sprite 0 overrides everything.
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            px  = hpos - xl_q[i];
            idx = px[3:0];
`ifdef SPRITE_MIRROR_EN
            if (sprite_flip[i])
                idx = ~px[3:0];
`endif
            nib = line_buf_q[i][{~idx, 2'b00} +: 4];
            if (px < 10'd16 && nib[0]) begin
                hit_c = 1'b1;
                rgb_c = nib[3:1];
            end
        end
        pixel_hit_d = active && (state_q == IDLE) && hit_c;
        pixel_rgb_d = pixel_hit_d ? rgb_c : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            target_q    <= '0;
            rom_line_q  <= '0;
            busy_q      <= 1'b0;
            fetch_vld_q <= 1'b0;
            fetch_idx_q <= '0;
            fetch_hit_q <= 1'b0;
            pixel_rgb_q <= '0;
            pixel_hit_q <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                line_buf_q[i] <= '0;
                xl_q[i]       <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            target_q    <= target_d;
            rom_line_q  <= rom_line_d;
            busy_q      <= busy_d;
            fetch_vld_q <= fetch_vld_d;
            fetch_idx_q <= fetch_idx_d;
            fetch_hit_q <= fetch_hit_d;
            pixel_rgb_q <= pixel_rgb_d;
            pixel_hit_q <= pixel_hit_d;
            line_buf_q  <= line_buf_d;
            xl_q        <= xl_d;
        end
    end

    assign rom_line  = rom_line_q;
    assign busy      = busy_q;
    assign pixel_rgb = pixel_rgb_q;
    assign pixel_hit = pixel_hit_q;

endmodule
